// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
// Module  : vga_pkg
// Purpose : Shared VGA constants and packed-field slice helpers.
// Revision: 1.0 - initial release
// ============================================================================

`ifndef VGA_PKG_MACROS
`define VGA_PKG_MACROS
// Field idx of width w inside a flat packed vector.
`define VGA_FIELD(vec, idx, w) vec[(idx)*(w) +: (w)]
`endif

package vga_pkg;
    localparam logic [11:0] KEY_DEFAULT   = 12'hFFF;
    localparam int          H_VISIBLE     = 640;
    localparam int          V_VISIBLE     = 480;
    localparam int          ROW_W_DEFAULT = 6;
    localparam int          COL_W_DEFAULT = 8;
    localparam int          COORD_W       = 10;
    localparam int          COLOR_W       = 12;
endpackage

`default_nettype wire

// File: rtl/pipe_delay.sv
`default_nettype none
// ============================================================================
// Module  : pipe_delay
// Purpose : DEPTH-stage register delay line, synchronous reset to zero.
// Revision: 1.0 - initial release
// ============================================================================

module pipe_delay #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data
);

    logic [WIDTH-1:0] r_stage [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) begin
                r_stage[k] <= '0;
            end
        end else begin
            r_stage[0] <= i_data;
            for (int k = 1; k < DEPTH; k++) begin
                r_stage[k] <= r_stage[k-1];
            end
        end
    end

    assign o_data = r_stage[DEPTH-1];

endmodule

`default_nettype wire

// File: rtl/sprite_overlay_mux.sv
`default_nettype none
// ============================================================================
// Module  : sprite_overlay_mux
// Purpose : Frame-latched multi-sprite compositor with colour keying,
//           fixed priority and overlap detection.
// Revision: 1.0 - initial release
// ============================================================================

module sprite_overlay_mux
    import vga_pkg::*;
#(
    parameter int          N_SPR        = 4,
    parameter int          ROW_W        = ROW_W_DEFAULT,
    parameter int          COL_W        = COL_W_DEFAULT,
    parameter int          ROM_LAT      = 1,
    parameter logic [11:0] KEY          = KEY_DEFAULT,
    parameter int          V_LATCH      = V_VISIBLE,
    parameter int          BLINK_FRAMES = 30
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       bright,
    input  logic [9:0]                 hCount,
    input  logic [9:0]                 vCount,
    input  logic [11:0]                background,
    input  logic [N_SPR*10-1:0]        pos_x,
    input  logic [N_SPR*10-1:0]        pos_y,
    input  logic [N_SPR*(COL_W+1)-1:0] size_w,
    input  logic [N_SPR*(ROW_W+1)-1:0] size_h,
    input  logic [N_SPR-1:0]           en,
    input  logic [N_SPR-1:0]           blink,
    output logic [N_SPR*ROW_W-1:0]     rom_row,
    output logic [N_SPR*COL_W-1:0]     rom_col,
    input  logic [N_SPR*12-1:0]        rom_color,
    output logic [11:0]                rgb,
    output logic [N_SPR-1:0]           sprite_hit,
    output logic                       collision
);

    localparam int c_FC_W   = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam int c_PIPE_W = N_SPR + 1 + 12;

    logic [9:0]       r_sh_x     [N_SPR];
    logic [9:0]       r_sh_y     [N_SPR];
    logic [COL_W:0]   r_sh_w     [N_SPR];
    logic [ROW_W:0]   r_sh_h     [N_SPR];
    logic [N_SPR-1:0] r_sh_en;
    logic [N_SPR-1:0] r_sh_blink;
    logic [c_FC_W-1:0] r_frame_cnt;
    logic             r_phase;

    logic             w_frame_evt;
    logic [N_SPR-1:0] w_on;

    assign w_frame_evt = (hCount == 10'd0) && (vCount == 10'(V_LATCH));

    // Shadow registers and blink phase only move on the frame event.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_SPR; i++) begin
                r_sh_x[i] <= '0;
                r_sh_y[i] <= '0;
                r_sh_w[i] <= '0;
                r_sh_h[i] <= '0;
            end
            r_sh_en     <= '0;
            r_sh_blink  <= '0;
            r_frame_cnt <= '0;
            r_phase     <= 1'b1;
        end else if (w_frame_evt) begin
            for (int i = 0; i < N_SPR; i++) begin
                r_sh_x[i] <= `VGA_FIELD(pos_x, i, 10);
                r_sh_y[i] <= `VGA_FIELD(pos_y, i, 10);
                r_sh_w[i] <= `VGA_FIELD(size_w, i, COL_W+1);
                r_sh_h[i] <= `VGA_FIELD(size_h, i, ROW_W+1);
            end
            r_sh_en    <= en;
            r_sh_blink <= blink;
            if (r_frame_cnt == c_FC_W'(BLINK_FRAMES - 1)) begin
                r_frame_cnt <= '0;
                r_phase     <= ~r_phase;
            end else begin
                r_frame_cnt <= r_frame_cnt + 1'b1;
            end
        end
    end

    // 11-bit window bounds so x+w never wraps back onto the left edge.
    for (genvar i = 0; i < N_SPR; i++) begin : g_win
        logic [10:0] w_h;
        logic [10:0] w_v;
        logic [10:0] w_x_end;
        logic [10:0] w_y_end;

        assign w_h     = {1'b0, hCount};
        assign w_v     = {1'b0, vCount};
        assign w_x_end = {1'b0, r_sh_x[i]} + 11'(r_sh_w[i]);
        assign w_y_end = {1'b0, r_sh_y[i]} + 11'(r_sh_h[i]);

        assign w_on[i] = r_sh_en[i] && (r_phase || !r_sh_blink[i])
                      && (w_h >= {1'b0, r_sh_x[i]}) && (w_h < w_x_end)
                      && (w_v >= {1'b0, r_sh_y[i]}) && (w_v < w_y_end);

        assign `VGA_FIELD(rom_row, i, ROW_W) = w_on[i] ? ROW_W'(vCount - r_sh_y[i]) : '0;
        assign `VGA_FIELD(rom_col, i, COL_W) = w_on[i] ? COL_W'(hCount - r_sh_x[i]) : '0;
    end

    logic [N_SPR-1:0] w_on_d;
    logic             w_bright_d;
    logic [11:0]      w_bg_d;

    pipe_delay #(
        .WIDTH (c_PIPE_W),
        .DEPTH (ROM_LAT)
    ) u_align (
        .clk    (clk),
        .rst    (rst),
        .i_data ({w_on, bright, background}),
        .o_data ({w_on_d, w_bright_d, w_bg_d})
    );

    logic [N_SPR-1:0] w_op;
    logic [11:0]      w_pix;
    logic             w_seen;
    logic             w_multi;

    // Descending scan so the lowest opaque index is the last to write w_pix.
    always_comb begin
        w_op    = '0;
        w_pix   = w_bg_d;
        w_seen  = 1'b0;
        w_multi = 1'b0;
        for (int i = N_SPR - 1; i >= 0; i--) begin
            w_op[i] = w_on_d[i] && (`VGA_FIELD(rom_color, i, 12) != KEY);
            if (w_op[i]) begin
                w_pix   = `VGA_FIELD(rom_color, i, 12);
                w_multi = w_multi | w_seen;
                w_seen  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || !w_bright_d) begin
            rgb        <= '0;
            sprite_hit <= '0;
            collision  <= 1'b0;
        end else begin
            rgb        <= w_pix;
            sprite_hit <= w_op;
            collision  <= w_multi;
        end
    end

endmodule

`default_nettype wire
